// File: rtl/result_collector.sv
// Collects registered results from the upstream 8-bit adder stage into a small show-ahead FIFO
// and keeps running statistics (sum, carry count, sticky wrap flag) over every accepted result.
module result_collector #(
  parameter int DEPTH = 4  // power of two, 2..16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_c,
  input  logic                     in_cout,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [8:0]               out_data,
  input  logic                     out_ready,
  input  logic                     acc_clr,
  output logic [15:0]              acc,
  output logic [7:0]               carry_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   acc_q, acc_d;
  logic [7:0]    carry_cnt_q, carry_cnt_d;
  logic          overflow_q, overflow_d;

  logic          push;
  logic          pop;
  logic [8:0]    push_data;
  logic [16:0]   acc_sum;

  // Handshake: in_ready depends only on occupancy, so a pop while full never frees a slot early.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign push_data = {in_cout, in_c};

  // Storage is left unreset; out_data masking keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  assign acc_sum = {1'b0, acc_q} + {8'h00, push_data};

  // Clear wins over accumulation, but never gates the FIFO push itself.
  always_comb begin
    acc_d       = acc_q;
    carry_cnt_d = carry_cnt_q;
    overflow_d  = overflow_q;
    if (acc_clr) begin
      acc_d       = '0;
      carry_cnt_d = '0;
      overflow_d  = 1'b0;
    end else if (push) begin
      acc_d      = acc_sum[15:0];
      overflow_d = overflow_q | acc_sum[16];
      if (in_cout && (carry_cnt_q != 8'hFF)) begin
        carry_cnt_d = carry_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      carry_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      carry_cnt_q <= carry_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_data  = out_valid ? mem_q[rd_ptr_q] : 9'h000;
  assign acc       = acc_q;
  assign carry_cnt = carry_cnt_q;
  assign overflow  = overflow_q;
  assign count     = count_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector (DEPTH=4): FIFO ordering, backpressure,
// statistics wrap/saturation, acc_clr interaction and reset behaviour.
module tb_result_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_c;
  logic       in_cout;
  logic       in_ready;
  logic       out_valid;
  logic [8:0] out_data;
  logic       out_ready;
  logic       acc_clr;
  logic [15:0] acc;
  logic [7:0] carry_cnt;
  logic       overflow;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  result_collector #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_c      (in_c),
    .in_cout   (in_cout),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .acc_clr   (acc_clr),
    .acc       (acc),
    .carry_cnt (carry_cnt),
    .overflow  (overflow),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid  = 1'b0;
    in_c      = 8'h00;
    in_cout   = 1'b0;
    out_ready = 1'b0;
    acc_clr   = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 9'h000) begin errors++; $display("FAIL reset_out_data got %h want 000", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (acc !== 16'h0000) begin errors++; $display("FAIL reset_acc got %h want 0000", acc); end
    checks++; if (carry_cnt !== 8'd0) begin errors++; $display("FAIL reset_carry_cnt got %0d want 0", carry_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    // pop while empty must do nothing
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL empty_pop_count got %0d want 0", count); end
    $display("test_reset done");
  endtask

  task automatic test_basic;
    do_reset();
    in_valid = 1'b1; in_cout = 1'b0; in_c = 8'h60;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL valid_after_push got %b want 1", out_valid); end
    in_c = 8'hC0;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL basic_count got %0d want 2", count); end
    checks++; if (out_data !== 9'h060) begin errors++; $display("FAIL basic_head got %h want 060", out_data); end
    checks++; if (acc !== 16'h0120) begin errors++; $display("FAIL basic_acc got %h want 0120", acc); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 9'h0C0) begin errors++; $display("FAIL basic_pop1 got %h want 0C0", out_data); end
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 9'h000) begin errors++; $display("FAIL basic_empty_data got %h want 000", out_data); end
    $display("test_basic done");
  endtask

  task automatic test_full;
    do_reset();
    in_valid = 1'b1; in_cout = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_c = 8'(i);
      tick();
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    in_c = 8'h05;
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
    checks++; if (acc !== 16'h000A) begin errors++; $display("FAIL full_acc got %h want 000A", acc); end
    // pop while full with in_valid held: only the pop happens
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_poppush_count got %0d want 3", count); end
    checks++; if (acc !== 16'h000A) begin errors++; $display("FAIL full_poppush_acc got %h want 000A", acc); end
    for (int i = 2; i <= 4; i++) begin
      checks++; if (out_data !== 9'(i)) begin errors++; $display("FAIL full_drain got %h want %h", out_data, 9'(i)); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drained got %0d want 0", count); end
    $display("test_full done");
  endtask

  task automatic test_back_to_back;
    do_reset();
    in_valid = 1'b1; in_cout = 1'b0; in_c = 8'h11;
    tick();
    in_c = 8'h22;
    tick();
    out_ready = 1'b1;
    in_c = 8'h33;
    tick();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count1 got %0d want 2", count); end
    checks++; if (out_data !== 9'h022) begin errors++; $display("FAIL b2b_head1 got %h want 022", out_data); end
    in_c = 8'h44;
    tick();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count2 got %0d want 2", count); end
    checks++; if (out_data !== 9'h033) begin errors++; $display("FAIL b2b_head2 got %h want 033", out_data); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_data !== 9'h044) begin errors++; $display("FAIL b2b_head3 got %h want 044", out_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count3 got %0d want 1", count); end
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_count4 got %0d want 0", count); end
    checks++; if (acc !== 16'h00AA) begin errors++; $display("FAIL b2b_acc got %h want 00AA", acc); end
    $display("test_back_to_back done");
  endtask

  task automatic test_acc_clr;
    do_reset();
    in_valid = 1'b1; in_cout = 1'b1; in_c = 8'h00;
    tick();
    checks++; if (carry_cnt !== 8'd1) begin errors++; $display("FAIL clr_pre_carry got %0d want 1", carry_cnt); end
    in_c = 8'hFF; acc_clr = 1'b1;
    tick();
    in_valid = 1'b0; acc_clr = 1'b0;
    checks++; if (acc !== 16'h0000) begin errors++; $display("FAIL clr_acc got %h want 0000", acc); end
    checks++; if (carry_cnt !== 8'd0) begin errors++; $display("FAIL clr_carry got %0d want 0", carry_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow got %b want 0", overflow); end
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL clr_count got %0d want 2", count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_data !== 9'h1FF) begin errors++; $display("FAIL clr_entry got %h want 1FF", out_data); end
    $display("test_acc_clr done");
  endtask

  task automatic test_carry_wrap;
    do_reset();
    in_valid = 1'b1; in_cout = 1'b1; in_c = 8'h00; out_ready = 1'b1;
    repeat (255) tick();
    checks++; if (carry_cnt !== 8'd255) begin errors++; $display("FAIL wrap_carry255 got %0d want 255", carry_cnt); end
    checks++; if (acc !== 16'hFF00) begin errors++; $display("FAIL wrap_acc255 got %h want FF00", acc); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf255 got %b want 0", overflow); end
    tick();
    checks++; if (acc !== 16'h0000) begin errors++; $display("FAIL wrap_acc256 got %h want 0000", acc); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL wrap_ovf256 got %b want 1", overflow); end
    checks++; if (carry_cnt !== 8'd255) begin errors++; $display("FAIL wrap_carry_sat got %0d want 255", carry_cnt); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count got %0d want 1", count); end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL wrap_sticky got %b want 1", overflow); end
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_clr_ovf got %b want 0", overflow); end
    checks++; if (carry_cnt !== 8'd0) begin errors++; $display("FAIL wrap_clr_carry got %0d want 0", carry_cnt); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_clr_count got %0d want 1", count); end
    $display("test_carry_wrap done");
  endtask

  task automatic test_reset_mid;
    do_reset();
    in_valid = 1'b1; in_cout = 1'b1; in_c = 8'h00;
    repeat (3) tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got %0d want 3", count); end
    checks++; if (acc !== 16'h0300) begin errors++; $display("FAIL mid_pre_acc got %h want 0300", acc); end
    // reset must dominate a simultaneous push, pop and clear
    rst_n = 1'b0; in_cout = 1'b0; in_c = 8'h55; out_ready = 1'b1; acc_clr = 1'b1;
    tick();
    rst_n = 1'b1;
    idle_inputs();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 9'h000) begin errors++; $display("FAIL mid_out_data got %h want 000", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
    checks++; if (acc !== 16'h0000) begin errors++; $display("FAIL mid_acc got %h want 0000", acc); end
    checks++; if (carry_cnt !== 8'd0) begin errors++; $display("FAIL mid_carry got %0d want 0", carry_cnt); end
    in_valid = 1'b1; in_c = 8'hAB;
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== 9'h0AB) begin errors++; $display("FAIL mid_head got %h want 0AB", out_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL mid_post_count got %0d want 1", count); end
    $display("test_reset_mid done");
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_acc_clr();
    test_carry_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
